// File: rtl/alu_pkg.sv
// Shared opcode encodings, widths and the stored-result record for the ALU issue stage.
package alu_pkg;

  localparam int DATA_W      = 8;
  localparam int OPC_W       = 4;
  localparam int FLAG_W      = 3;
  localparam int RES_W       = 12;
  localparam int ILLEGAL_MIN = 9;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND   = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR    = 4'd3;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OPC_W-1:0] OP_NAND  = 4'd5;
  localparam logic [OPC_W-1:0] OP_NOR   = 4'd6;
  localparam logic [OPC_W-1:0] OP_XNOR  = 4'd7;
  localparam logic [OPC_W-1:0] OP_SHIFT = 4'd8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              ovf;
    logic              zero;
    logic              illegal;
  } res_t;

  // Illegal opcodes discard whatever the ALU produced so the consumer sees a clean marker.
  function automatic res_t make_result(input logic [DATA_W-1:0] out,
                                       input logic carry,
                                       input logic ovf,
                                       input logic zero,
                                       input logic illegal);
    res_t r;
    r = '0;
    if (illegal) begin
      r.illegal = 1'b1;
    end else begin
      r.data  = out;
      r.carry = carry;
      r.ovf   = ovf;
      r.zero  = zero;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Small synchronous result FIFO; the head output holds the last popped entry while empty.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [RES_W-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [RES_W-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [RES_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [RES_W-1:0] r_last;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for the external 8-bit ALU: operand register in front, result FIFO and
// sticky carry/overflow status behind.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int RES_DEPTH   = 2,
  parameter int ILLEGAL_MIN = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_a,
  input  logic [7:0]        in_b,
  input  logic [3:0]        in_opcode,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [7:0]        alu_out,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_data,
  output logic [2:0]        res_flags,
  output logic              res_illegal,
  output logic              stat_carry,
  output logic              stat_ovf,
  input  logic              stat_clr
);

  localparam int CNT_W = $clog2(RES_DEPTH) + 1;

  logic             r_op_v;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [3:0]       r_opcode;
  logic             r_stat_carry;
  logic             r_stat_ovf;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_accept;
  logic             w_illegal;
  res_t             w_wres;
  res_t             w_rres;
  logic [RES_W-1:0] w_rdata;

  assign w_push    = r_op_v & ~w_full;
  // Ready is forced low during reset so nothing is taken while the stage is held.
  assign in_ready  = rst_n & (~r_op_v | w_push);
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = res_ready & (w_count != '0);
  assign w_illegal = (r_opcode >= OPC_W'(ILLEGAL_MIN));
  assign w_wres    = make_result(alu_out, alu_carry, alu_overflow, alu_zero, w_illegal);

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_v   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_opcode <= '0;
    end else if (w_accept) begin
      r_op_v   <= 1'b1;
      r_a      <= in_a;
      r_b      <= in_b;
      r_opcode <= in_opcode;
    end else if (w_push) begin
      r_op_v   <= 1'b0;
    end
  end

  // A capture in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_carry <= 1'b0;
      r_stat_ovf   <= 1'b0;
    end else begin
      r_stat_carry <= (w_push & w_wres.carry) | (r_stat_carry & ~stat_clr);
      r_stat_ovf   <= (w_push & w_wres.ovf)   | (r_stat_ovf   & ~stat_clr);
    end
  end

  assign stat_carry = r_stat_carry;
  assign stat_ovf   = r_stat_ovf;

  alu_result_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wres),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_rres      = res_t'(w_rdata);
  assign res_valid   = ~w_empty;
  assign res_data    = w_rres.data;
  assign res_flags   = {w_rres.carry, w_rres.ovf, w_rres.zero};
  assign res_illegal = w_rres.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against a queue-based transaction model.
module tb_alu_issue_stage;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [3:0] in_opcode;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_opcode;
  logic       alu_carry, alu_overflow, alu_zero;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [2:0] res_flags;
  logic       res_illegal;
  logic       stat_carry, stat_ovf, stat_clr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.RES_DEPTH(DEPTH), .ILLEGAL_MIN(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags), .res_illegal(res_illegal),
    .stat_carry(stat_carry), .stat_ovf(stat_ovf), .stat_clr(stat_clr)
  );

  // Behavioural ALU; returns {result, carry, overflow, zero}. Illegal opcodes yield garbage.
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int unsigned s;
    logic [7:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; s = 0;
    case (op)
      4'd0: begin s = {24'b0, a} + {24'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~(a & b);
      4'd6: r = ~(a | b);
      4'd7: r = ~(a ^ b);
      4'd8: begin s = {24'b0, a} << b[7:4]; r = s[7:0]; c = |s[15:8]; end
      default: begin r = a ^ b; c = 1'b1; v = 1'b1; end
    endcase
    return {r, c, v, (r == 8'h00)};
  endfunction

  always_comb {alu_out, alu_carry, alu_overflow, alu_zero} = alu_f(alu_a, alu_b, alu_opcode);

  // Expected stored entry {data, carry, ovf, zero, illegal}
  function automatic logic [11:0] exp_res(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    if (op >= 4'd9) return 12'h001;
    return {alu_f(a, b, op), 1'b0};
  endfunction

  // Transaction model: one optional pending operand, a bounded result queue, sticky bits.
  bit          m_opv;
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_op;
  logic [11:0] m_q[$];
  logic [11:0] m_last;
  bit          m_sc, m_so;
  bit          m_acc;

  task automatic model_reset();
    m_opv = 0; m_a = '0; m_b = '0; m_op = '0;
    m_q.delete(); m_last = '0; m_sc = 0; m_so = 0; m_acc = 0;
  endtask

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [11:0] h;
    h = (m_q.size() > 0) ? m_q[0] : m_last;
    chk_val("in_ready", in_ready, !m_opv || (m_q.size() < DEPTH));
    chk_val("res_valid", res_valid, m_q.size() > 0);
    chk_val("res_data", res_data, h[11:4]);
    chk_val("res_flags", res_flags, h[3:1]);
    chk_val("res_illegal", res_illegal, h[0]);
    chk_val("stat_carry", stat_carry, m_sc);
    chk_val("stat_ovf", stat_ovf, m_so);
    chk_val("alu_a", alu_a, m_a);
    chk_val("alu_b", alu_b, m_b);
    chk_val("alu_opcode", alu_opcode, m_op);
  endtask

  // One clock: predict from current state and inputs, let the edge happen, then compare.
  task automatic tick();
    bit push, pop, acc;
    logic [11:0] pr;
    pr   = '0;
    push = m_opv && (m_q.size() < DEPTH);
    pop  = (m_q.size() > 0) && res_ready;
    acc  = in_valid && (!m_opv || push);
    @(posedge clk); #1;
    if (pop) m_last = m_q.pop_front();
    if (push) begin
      pr = exp_res(m_a, m_b, m_op);
      m_q.push_back(pr);
    end
    m_sc = (push && pr[3]) || (m_sc && !stat_clr);
    m_so = (push && pr[2]) || (m_so && !stat_clr);
    if (acc) begin
      m_a = in_a; m_b = in_b; m_op = in_opcode; m_opv = 1;
    end else if (push) begin
      m_opv = 0;
    end
    m_acc = acc;
    check_all();
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    bit done;
    done = 0;
    in_a = a; in_b = b; in_opcode = op; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = m_acc;
    end
    if (!done) chk_val("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic sc0, so0;
    model_reset();
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_opcode = 4'd0;
    res_ready = 1'b0; stat_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_in_ready", in_ready, 0);
    chk_val("rst_res_valid", res_valid, 0);
    chk_val("rst_stat_carry", stat_carry, 0);
    chk_val("rst_stat_ovf", stat_ovf, 0);
    chk_val("rst_alu_a", alu_a, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_val("post_rst_ready", in_ready, 1);

    // Add with carry
    res_ready = 1'b1;
    send(8'hF0, 8'h20, 4'd0);
    chk_val("add_lat_novalid", res_valid, 0);
    tick();
    chk_val("add_valid", res_valid, 1);
    chk_val("add_data", res_data, 8'h10);
    chk_val("add_flags", res_flags, 3'b100);
    chk_val("add_stat_carry", stat_carry, 1);
    tick();

    // Back-pressure
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(5 + i), 8'h05, 4'd1);
    in_a = 8'h08; in_b = 8'h05; in_opcode = 4'd1; in_valid = 1'b1;
    repeat (3) tick();
    chk_val("bp_ready_low", in_ready, 0);
    chk_val("bp_head_data", res_data, 8'h00);
    chk_val("bp_head_zero", res_flags[0], 1);
    res_ready = 1'b1;
    in_valid = 1'b0;
    send(8'h08, 8'h05, 4'd1);
    repeat (5) tick();
    chk_val("bp_drained", res_valid, 0);

    // Illegal opcode
    sc0 = stat_carry; so0 = stat_ovf;
    res_ready = 1'b0;
    send(8'hFF, 8'h01, 4'hC);
    tick();
    chk_val("ill_flag", res_illegal, 1);
    chk_val("ill_data", res_data, 0);
    chk_val("ill_flags", res_flags, 0);
    chk_val("ill_sc", stat_carry, sc0);
    chk_val("ill_so", stat_ovf, so0);
    res_ready = 1'b1;
    tick();

    // Sticky collision
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    send(8'h7F, 8'h01, 4'd0);
    stat_clr = 1'b1;
    tick();
    chk_val("coll_ovf_set", stat_ovf, 1);
    tick();
    chk_val("coll_ovf_clr", stat_ovf, 0);
    stat_clr = 1'b0;

    // Mid-operation reset
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(8'h30 + i), 8'h11, 4'd3);
    chk_val("mid_full_valid", res_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_val("mid_rst_valid", res_valid, 0);
    chk_val("mid_rst_ready", in_ready, 0);
    chk_val("mid_rst_alu_a", alu_a, 0);
    model_reset();
    #2 rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (4) tick();
    chk_val("mid_no_stale", res_valid, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_opcode = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 9) < 6);
      stat_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
